// File: rtl/ccd_cds_pkg.sv
// Shared types and constants for the CCD correlated-double-sample block:
// FSM state encoding, register offsets, STATUS bit positions and reset values.
`timescale 1ns/1ps
package ccd_cds_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitR,
    StSetR,
    StConvR,
    StWaitS,
    StSetS,
    StConvS,
    StStore
  } state_e;

  localparam logic [4:0] RegCtrl   = 5'h00;
  localparam logic [4:0] RegStatus = 5'h04;
  localparam logic [4:0] RegData   = 5'h08;
  localparam logic [4:0] RegPixels = 5'h0C;
  localparam logic [4:0] RegOffset = 5'h10;

  localparam int unsigned CtrlEnableBit = 0;
  localparam int unsigned CtrlClearBit  = 1;

  localparam int unsigned StEmptyBit    = 8;
  localparam int unsigned StFullBit     = 9;
  localparam int unsigned StOverflowBit = 10;
  localparam int unsigned StTimeoutBit  = 11;
  localparam int unsigned StLineDoneBit = 12;

  localparam logic [15:0] PixelsRst = 16'd512;

endpackage

// File: rtl/ccd_cds_fifo.sv
// Synchronous first-word-fall-through FIFO for CDS results. A pop on a full FIFO frees the
// slot in the same cycle, so a simultaneous push is accepted; flush has priority over both.
`timescale 1ns/1ps
module ccd_cds_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] DepthL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == DepthL);
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ccd_cds_sampler.sv
// CCD correlated-double sampler: tracks phi_r/phi_l1, drives the ADC, buffers CDS results for
// Wishbone readout. Define CCD_CDS_OFFSET_EN to add the signed OFFSET register at 0x10.
`timescale 1ns/1ps
module ccd_cds_sampler
  import ccd_cds_pkg::*;
#(
  parameter int unsigned ADC_W       = 12,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned RST_SETTLE  = 4,
  parameter int unsigned SIG_SETTLE  = 4,
  parameter int unsigned ADC_TIMEOUT = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0020
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic             phi_r_i,
  input  logic             phi_l1_i,
  output logic             adc_conv_o,
  input  logic [ADC_W-1:0] adc_data_i,
  input  logic             adc_valid_i,
  output logic             line_done_o
);

  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

  // Phase synchronisers and edge detect
  logic phi_r_meta_q, phi_r_sync_q, phi_r_prev_q;
  logic phi_l1_meta_q, phi_l1_sync_q, phi_l1_prev_q;
  logic phi_r_fall, phi_l1_rise;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      phi_r_meta_q  <= 1'b0;
      phi_r_sync_q  <= 1'b0;
      phi_r_prev_q  <= 1'b0;
      phi_l1_meta_q <= 1'b0;
      phi_l1_sync_q <= 1'b0;
      phi_l1_prev_q <= 1'b0;
    end else begin
      phi_r_meta_q  <= phi_r_i;
      phi_r_sync_q  <= phi_r_meta_q;
      phi_r_prev_q  <= phi_r_sync_q;
      phi_l1_meta_q <= phi_l1_i;
      phi_l1_sync_q <= phi_l1_meta_q;
      phi_l1_prev_q <= phi_l1_sync_q;
    end
  end

  assign phi_r_fall  = phi_r_prev_q & ~phi_r_sync_q;
  assign phi_l1_rise = ~phi_l1_prev_q & phi_l1_sync_q;

  // Wishbone decode
  logic       ack_q;
  logic [31:0] dat_q;
  logic       wb_req, reg_hit, wr, rd;
  logic [4:0] reg_off;
  logic       clear;
  logic [2:0] sts_w1c;

  assign wb_req  = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign reg_hit = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign reg_off = wbs_adr_i[4:0];
  assign wr      = wb_req & wbs_we_i & reg_hit;
  assign rd      = wb_req & ~wbs_we_i & reg_hit;
  assign clear   = wr & (reg_off == RegCtrl) & wbs_sel_i[0] & wbs_dat_i[CtrlClearBit];
  assign sts_w1c = (wr && reg_off == RegStatus && wbs_sel_i[1]) ?
                   wbs_dat_i[StLineDoneBit:StOverflowBit] : 3'b000;

  logic unused_wb;
  assign unused_wb = ^{wbs_dat_i[31:16], wbs_sel_i[3:2]};

  // Control registers
  logic        enable_q;
  logic [15:0] pixels_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      enable_q <= 1'b0;
      pixels_q <= PixelsRst;
    end else begin
      if (wr && reg_off == RegCtrl && wbs_sel_i[0]) enable_q <= wbs_dat_i[CtrlEnableBit];
      if (wr && reg_off == RegPixels) begin
        if (wbs_sel_i[0]) pixels_q[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) pixels_q[15:8] <= wbs_dat_i[15:8];
      end
    end
  end

  // CDS arithmetic
  logic [ADC_W-1:0] rst_smp_q, rst_smp_d;
  logic [ADC_W-1:0] sig_smp_q, sig_smp_d;
  logic [15:0]      cds;

`ifdef CCD_CDS_OFFSET_EN
  logic [15:0]        offset_q;
  logic signed [17:0] cds_sum;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      offset_q <= '0;
    end else if (wr && reg_off == RegOffset) begin
      if (wbs_sel_i[0]) offset_q[7:0]  <= wbs_dat_i[7:0];
      if (wbs_sel_i[1]) offset_q[15:8] <= wbs_dat_i[15:8];
    end
  end

  // Zero-extend both samples, sign-extend the offset; 18 bits holds every combination
  assign cds_sum = $signed(18'(rst_smp_q)) - $signed(18'(sig_smp_q))
                 + $signed({{2{offset_q[15]}}, offset_q});

  always_comb begin
    if (cds_sum < 0)               cds = 16'h0000;
    else if (cds_sum > 18'sd65535) cds = 16'hFFFF;
    else                           cds = cds_sum[15:0];
  end
`else
  assign cds = (rst_smp_q < sig_smp_q) ? 16'h0000 : 16'(rst_smp_q - sig_smp_q);
`endif

  // Sampling FSM
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        conv_q, conv_d;
  logic        store, tmo_set;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      conv_q    <= 1'b0;
      rst_smp_q <= '0;
      sig_smp_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      conv_q    <= conv_d;
      rst_smp_q <= rst_smp_d;
      sig_smp_q <= sig_smp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    conv_d    = 1'b0;
    rst_smp_d = rst_smp_q;
    sig_smp_d = sig_smp_q;
    store     = 1'b0;
    tmo_set   = 1'b0;
    if (clear || !enable_q) begin
      // Any partial pixel is abandoned; already-stored results stay in the FIFO
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StWaitR;
          cnt_d   = '0;
        end
        StWaitR: begin
          if (phi_r_fall) begin
            state_d = StSetR;
            cnt_d   = '0;
          end
        end
        StSetR: begin
          if (cnt_q == 16'(RST_SETTLE - 1)) begin
            conv_d  = 1'b1;
            state_d = StConvR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StConvR: begin
          if (adc_valid_i) begin
            rst_smp_d = adc_data_i;
            state_d   = StWaitS;
            cnt_d     = '0;
          end else if (cnt_q == 16'(ADC_TIMEOUT - 1)) begin
            tmo_set = 1'b1;
            state_d = StWaitR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StWaitS: begin
          if (phi_l1_rise) begin
            state_d = StSetS;
            cnt_d   = '0;
          end
        end
        StSetS: begin
          if (cnt_q == 16'(SIG_SETTLE - 1)) begin
            conv_d  = 1'b1;
            state_d = StConvS;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StConvS: begin
          if (adc_valid_i) begin
            sig_smp_d = adc_data_i;
            state_d   = StStore;
            cnt_d     = '0;
          end else if (cnt_q == 16'(ADC_TIMEOUT - 1)) begin
            tmo_set = 1'b1;
            state_d = StWaitR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StStore: begin
          store   = 1'b1;
          state_d = StWaitR;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Result FIFO
  logic [31:0]     fifo_rdata;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic [LvlW-1:0] fifo_level;
  logic [15:0]     pixel_idx_q;
  logic            ovf_set;

  assign fifo_pop = rd & (reg_off == RegData) & ~fifo_empty;
  assign ovf_set  = store & fifo_full & ~fifo_pop;

  ccd_cds_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .flush (clear),
    .push  (store),
    .pop   (fifo_pop),
    .wdata ({pixel_idx_q, cds}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Pixel counter and sticky status
  logic overflow_q, timeout_q, line_done_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clear) begin
      pixel_idx_q <= '0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      if (sts_w1c[0]) overflow_q  <= 1'b0;
      if (sts_w1c[1]) timeout_q   <= 1'b0;
      if (sts_w1c[2]) line_done_q <= 1'b0;
      if (ovf_set)    overflow_q  <= 1'b1;
      if (tmo_set)    timeout_q   <= 1'b1;
      // Index advances even when the entry is dropped on overflow
      if (store) begin
        if (pixel_idx_q == pixels_q - 16'd1) begin
          pixel_idx_q <= '0;
          line_done_q <= 1'b1;
        end else begin
          pixel_idx_q <= pixel_idx_q + 16'd1;
        end
      end
    end
  end

  // Read mux and Wishbone response
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (reg_hit) begin
      case (reg_off)
        RegCtrl:   rdata[CtrlEnableBit] = enable_q;
        RegStatus: begin
          rdata[LvlW-1:0]     = fifo_level;
          rdata[StEmptyBit]    = fifo_empty;
          rdata[StFullBit]     = fifo_full;
          rdata[StOverflowBit] = overflow_q;
          rdata[StTimeoutBit]  = timeout_q;
          rdata[StLineDoneBit] = line_done_q;
        end
        RegData:   if (!fifo_empty) rdata = fifo_rdata;
        RegPixels: rdata[15:0] = pixels_q;
`ifdef CCD_CDS_OFFSET_EN
        RegOffset: rdata[15:0] = offset_q;
`endif
        default:   rdata = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= wb_req;
      dat_q <= (wb_req && !wbs_we_i) ? rdata : 32'h0;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign adc_conv_o  = conv_q;
  assign line_done_o = line_done_q;

endmodule

// File: doc/ccd_cds_sampler.md
Name: ccd_cds_sampler

Overview:
- Downstream consumer of the CCD phase generator; tracks the phi_r and phi_l1 it drives to the sensor.
- Per pixel: commands an external ADC twice (reset level, then signal level) and computes the correlated-double-sample difference.
- Results are buffered in a 16-deep FIFO; firmware reads them over the Caravel Wishbone user bus.
- Counts pixels per line and raises a line-done interrupt.

Parameters:
- ADC_W, 12, ADC sample width.
- FIFO_DEPTH, 16, result FIFO entries; power of two.
- RST_SETTLE, 4, wb_clk_i cycles from detected phi_r fall to reset-level convert.
- SIG_SETTLE, 4, wb_clk_i cycles from detected phi_l1 rise to signal-level convert.
- ADC_TIMEOUT, 64, max cycles waiting for adc_valid_i.
- BASE_ADDR, 32'h3000_0020, Wishbone register base.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write enable.
- wbs_sel_i  in  4  byte select; writes honour it per byte.
- wbs_adr_i, wbs_dat_i  in  32  address, write data.
- wbs_ack_o  out  1  Wishbone acknowledge.
- wbs_dat_o  out  32  Wishbone read data.
- phi_r_i, phi_l1_i  in  1  phases from the signal generator; asynchronous.
- adc_conv_o  out  1  one-cycle convert pulse.
- adc_data_i  in  ADC_W  ADC result.
- adc_valid_i  in  1  result-valid strobe.
- line_done_o  out  1  level interrupt; cleared via STATUS.

Behaviour:
- Reset: all outputs 0; FIFO empty; counters 0; state IDLE; all registers 0 except PIXELS = 512.
- Phase inputs pass through a 2-flop synchroniser, then edge detect. An edge is usable 3 cycles after the pin transition.
- Registers (offsets from BASE_ADDR):
  - 0x0 CTRL: bit0 enable; bit1 clear, self-clearing; flushes FIFO, counters and sticky bits.
  - 0x4 STATUS: [4:0] fill level; bit8 empty; bit9 full; bit10 overflow sticky; bit11 timeout sticky; bit12 line_done. Writing 1 to bits 10-12 clears them.
  - 0x8 DATA: read returns {pixel_idx[15:0], cds[15:0]} and pops; reads 0 when empty, no pop.
  - 0xC PIXELS: pixels per line, 16 bit.
- Wishbone: wbs_ack_o is high for exactly one cycle, one cycle after stb&cyc. It drops even if stb is held. Unmapped addresses ack and read 0.
- FSM:
  - IDLE -> WAIT_R when enable=1.
  - WAIT_R -> SET_R on phi_r fall.
  - SET_R counts RST_SETTLE, then pulses adc_conv_o -> CONV_R.
  - CONV_R latches reset sample on adc_valid_i -> WAIT_S.
  - WAIT_S -> SET_S on phi_l1 rise.
  - SET_S counts SIG_SETTLE, then pulses adc_conv_o -> CONV_S.
  - CONV_S latches signal sample -> STORE.
  - STORE pushes one entry -> WAIT_R.
- CDS arithmetic: cds = reset - signal, zero-extended to 16 bits. A negative result saturates to 0.
- Timeout: CONV_R/CONV_S exceeding ADC_TIMEOUT cycles sets the timeout bit, drops the pixel and goes to WAIT_R. pixel_idx does not advance.
- pixel_idx increments on each STORE. On reaching PIXELS-1 it wraps to 0 and sets line_done.
- FIFO full at STORE: entry dropped, overflow set, pixel_idx still advances.
- Simultaneous push and pop on a full FIFO: pop occurs first, push succeeds.
- enable cleared mid-pixel: FSM returns to IDLE next cycle. The partial pixel is discarded; FIFO contents are kept.
- clear and push in the same cycle: clear wins.
- adc_valid_i outside CONV states is ignored.

Optional Feature:
- Macro CCD_CDS_OFFSET_EN.
- Defined: adds register 0x10 OFFSET (signed 16 bit). The stored value becomes sat0(reset - signal + OFFSET), clamped to 0..65535.
- Undefined: 0x10 is unmapped (reads 0, writes ignored); no adder is generated.

Decomposition:
- Package ccd_cds_pkg:
  - FSM state encoding.
  - Register offsets.
  - STATUS bit positions.
  - PIXELS reset value 512.
- Sub-module ccd_cds_fifo: synchronous FIFO, FIFO_DEPTH x 32, with push, pop, full, empty and level.
- Synchroniser and edge detect stay inline.

Test Plan:
- Reset then read STATUS -> 0x0000_0100 (empty only); PIXELS reads 512.
- enable=1; phi_r fall; ADC returns 0x800; phi_l1 rise; ADC returns 0x300. Expect:
  - adc_conv_o pulses exactly 3+RST_SETTLE and 3+SIG_SETTLE cycles after the respective pin edges.
  - DATA read -> 0x0000_0500; STATUS empty afterwards.
- Reset 0x100, signal 0x200 -> stored cds 0x0000. With CCD_CDS_OFFSET_EN and OFFSET=0x40, reset 0x200 / signal 0x100 -> 0x0140.
- PIXELS=4, four pixels -> line_done_o=1; fifth entry carries pixel_idx 0; writing 0x1000 to STATUS clears line_done_o.
- 17 pixels with no reads -> level 16, full=1, overflow=1; the first DATA read returns pixel_idx 0.
- adc_valid_i withheld 64 cycles in CONV_R -> timeout=1, nothing stored; the next complete pixel keeps the same pixel_idx.
